// File: rtl/cache_burst_transfer.sv
// rtl/cache_burst_transfer.sv - cache block refill / write-back burst sequencer over AXI beats
module cache_burst_transfer #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int BLOCK_WIDTH    = 512,
  parameter int WRAP_EN        = 0
) (
  input  logic                                           i_clk,
  input  logic                                           i_arst,
  input  logic                                           i_start_read,
  input  logic                                           i_start_write,
  input  logic                                           i_beat_done,
  input  logic [AXI_ADDR_WIDTH-1:0]                      i_addr_cache,
  input  logic [BLOCK_WIDTH-1:0]                         i_data_block_cache,
  input  logic [AXI_DATA_WIDTH-1:0]                      i_data_axi,
  output logic                                           o_busy,
  output logic                                           o_done,
  output logic                                           o_last,
  output logic [$clog2(BLOCK_WIDTH/AXI_DATA_WIDTH)-1:0]  o_beat_idx,
  output logic [AXI_ADDR_WIDTH-1:0]                      o_addr_axi,
  output logic [AXI_DATA_WIDTH-1:0]                      o_data_axi,
  output logic [BLOCK_WIDTH-1:0]                         o_data_block_cache
);

  localparam int BEATS       = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int BEAT_BYTES  = AXI_DATA_WIDTH / 8;
  localparam int BLOCK_BYTES = BLOCK_WIDTH / 8;
  localparam int IDX_W       = $clog2(BEATS);
  localparam int CNT_W       = IDX_W + 1;
  localparam int OFF_BEAT    = $clog2(BEAT_BYTES);
  localparam int OFF_BLK     = $clog2(BLOCK_BYTES);

  // Lane indexing and modulo-BEATS wrap rely on BEATS being a power of two.
  if ((BEATS < 2) || ((BEATS & (BEATS - 1)) != 0)) begin : g_bad_beats
    $error("cache_burst_transfer: BLOCK_WIDTH/AXI_DATA_WIDTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BLOCK_WIDTH-1:0]    hold_q, hold_d;
  logic [BLOCK_WIDTH-1:0]    blk_q, blk_d;

  logic [AXI_ADDR_WIDTH-1:0] addr_base;
  logic [IDX_W-1:0]          start_lane;
  logic                      unused_addr_bits;

  // Byte offset inside the block only selects the starting lane; the rest is dropped.
  assign addr_base        = {i_addr_cache[AXI_ADDR_WIDTH-1:OFF_BLK], {OFF_BLK{1'b0}}};
  assign start_lane       = (WRAP_EN != 0) ? i_addr_cache[OFF_BLK-1:OFF_BEAT] : '0;
  assign unused_addr_bits = ^i_addr_cache[OFF_BLK-1:0];

  // Base is block aligned, so OR-ing the lane offset is the same as adding it.
  function automatic logic [AXI_ADDR_WIDTH-1:0] lane_addr(
    input logic [AXI_ADDR_WIDTH-1:0] base,
    input logic [IDX_W-1:0]          lane
  );
    return base | (AXI_ADDR_WIDTH'(lane) << OFF_BEAT);
  endfunction

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      hold_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      blk_q   <= blk_d;
    end
  end

  // Next-state logic: start acceptance in IDLE only, beat advance in READ/WRITE.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    blk_d   = blk_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start_write || i_start_read) begin
          state_d = i_start_write ? ST_WRITE : ST_READ;
          base_d  = addr_base;
          idx_d   = start_lane;
          cnt_d   = CNT_W'(BEATS);
          addr_d  = lane_addr(addr_base, start_lane);
          if (i_start_write) begin
            hold_d = i_data_block_cache;
          end
        end
      end
      ST_READ, ST_WRITE: begin
        if (i_beat_done) begin
          idx_d  = idx_q + IDX_W'(1);
          cnt_d  = cnt_q - CNT_W'(1);
          addr_d = lane_addr(base_q, idx_q + IDX_W'(1));
          if (state_q == ST_READ) begin
            for (int k = 0; k < BEATS; k++) begin
              if (idx_q == IDX_W'(k)) begin
                blk_d[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = i_data_axi;
              end
            end
          end
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write beat data: lane mux from the holding register, zero outside WRITE.
  always_comb begin
    o_data_axi = '0;
    if (state_q == ST_WRITE) begin
      for (int k = 0; k < BEATS; k++) begin
        if (idx_q == IDX_W'(k)) begin
          o_data_axi = hold_q[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        end
      end
    end
  end

  assign o_busy             = (state_q != ST_IDLE);
  assign o_done             = (state_q == ST_DONE);
  assign o_last             = ((state_q == ST_READ) || (state_q == ST_WRITE)) && (cnt_q == CNT_W'(1));
  assign o_beat_idx         = idx_q;
  assign o_addr_axi         = addr_q;
  assign o_data_block_cache = blk_q;

endmodule
